memory_arbiter: RTL and testbench

Round-robin arbiter and access sequencer that shares one `memory_block` (cache plus backing memory, with its miss counter) between up to eight requesters, e.g. instruction fetch and data port. It accepts level-held request/acknowledge transactions, issues exactly one read or write at a time to the memory, waits out variable hit/miss latency via `mem_ready`, and returns read data with a one-cycle acknowledge.

---
 rtl/memory_arbiter_pkg.sv | 23 ++
 rtl/memory_arbiter_rr_select.sv | 32 +++
 rtl/memory_arbiter.sv | 113 +++++++++++
 tb/tb_memory_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter shared types: FSM states, requester index, stats width.
// Supplies fallback address/word widths when the core headers are absent.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  localparam int IDX_W  = 3;
  localparam int STAT_W = 32;

  typedef logic [IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/memory_arbiter_rr_select.sv
// rr_select: combinational round-robin pick, searching upward from last+1.
// Winner is the requester with the smallest rotated distance from last.
module rr_select
  import memory_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         last,
  output logic             valid,
  output req_idx_t         grant
);

  int d;
  int best;

  always_comb begin
    valid = 1'b0;
    grant = '0;
    best  = N_REQ;
    d     = 0;
    for (int j = 0; j < N_REQ; j++) begin
      d = (j + 2 * N_REQ - int'(last) - 1) % N_REQ;
      if (req[j] && d < best) begin
        best  = d;
        valid = 1'b1;
        grant = req_idx_t'(j);
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin sequencer sharing one memory_block among N_REQ.
// Define MEMORY_ARBITER_STATS_EN to add grant_count / busy_cycles counters.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = `ADDRESS_LEN,
  parameter int DW    = `WORD_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [N_REQ*AW-1:0]   req_address,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      ack,
  output logic [DW-1:0]         rdata,
  output logic [AW-1:0]         mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DW-1:0]         mem_data_in,
  input  logic [DW-1:0]         mem_data_out,
  input  logic                  mem_ready
`ifdef MEMORY_ARBITER_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] grant_count,
  output logic [STAT_W-1:0]       busy_cycles
`endif
);

  arb_state_t state;
  arb_state_t state_nxt;
  req_idx_t   g;
  req_idx_t   last;
  req_idx_t   sel;
  logic       sel_valid;
  logic       wr;

  rr_select #(
    .N_REQ(N_REQ)
  ) u_sel (
    .req  (req),
    .last (last),
    .valid(sel_valid),
    .grant(sel)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sel_valid) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      g           <= '0;
      wr          <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rdata       <= '0;
      last        <= req_idx_t'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_valid) begin
        g <= sel;
        for (int i = 0; i < N_REQ; i++) begin
          if (sel == req_idx_t'(i)) begin
            wr          <= req_write[i];
            mem_address <= req_address[i*AW +: AW];
            mem_data_in <= req_data[i*DW +: DW];
          end
        end
      end
      if (state == BUSY && mem_ready && !wr)
        rdata <= mem_data_out;
      if (state == DONE)
        last <= g;
    end
  end

  // Strobes and ack decode only from state and latched registers.
  always_comb begin
    mem_read  = (state == BUSY) && !wr;
    mem_write = (state == BUSY) && wr;
    ack       = '0;
    for (int i = 0; i < N_REQ; i++)
      ack[i] = (state == DONE) && (g == req_idx_t'(i));
  end

`ifdef MEMORY_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count <= '0;
      busy_cycles <= '0;
    end else begin
      if (state == BUSY && busy_cycles != '1)
        busy_cycles <= busy_cycles + STAT_W'(1);
      for (int i = 0; i < N_REQ; i++) begin
        if (state == DONE && g == req_idx_t'(i) &&
            grant_count[i*STAT_W +: STAT_W] != '1)
          grant_count[i*STAT_W +: STAT_W] <=
            grant_count[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed plus randomized transactions against a
// transaction-level round-robin and memory model.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int AW = `ADDRESS_LEN;
  localparam int DW = `WORD_LEN;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_address;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DW-1:0]     mem_data_in;
  logic [DW-1:0]     mem_data_out;
  logic              mem_ready;
`ifdef MEMORY_ARBITER_STATS_EN
  logic [NR*STAT_W-1:0] grant_count;
  logic [STAT_W-1:0]    busy_cycles;
`endif

  memory_arbiter #(
    .N_REQ(NR),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_write   (req_write),
    .req_address (req_address),
    .req_data    (req_data),
    .ack         (ack),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out),
    .mem_ready   (mem_ready)
`ifdef MEMORY_ARBITER_STATS_EN
    ,
    .grant_count (grant_count),
    .busy_cycles (busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  bit            pend [NR];
  bit            wr_q [NR];
  logic [AW-1:0] ad_q [NR];
  logic [DW-1:0] dt_q [NR];
  logic [DW-1:0] mem_m [logic [AW-1:0]];
  int            exp_last;
  logic [DW-1:0] exp_rdata;
  int            exp_gc [NR];
  longint        exp_busy;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req[i]                 = pend[i];
      req_write[i]           = wr_q[i];
      req_address[i*AW +: AW] = ad_q[i];
      req_data[i*DW +: DW]    = dt_q[i];
    end
  endtask

  task automatic post(input int i, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    pend[i] = 1'b1;
    wr_q[i] = w;
    ad_q[i] = a;
    dt_q[i] = d;
  endtask

  function automatic int pick();
    for (int i = 1; i <= NR; i++)
      if (pend[(exp_last + i) % NR]) return (exp_last + i) % NR;
    return 0;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (!mem_m.exists(a)) mem_m[a] = DW'($urandom);
    return mem_m[a];
  endfunction

  // Starts at a negedge before the IDLE sampling edge; ends at the next
  // IDLE cycle's negedge.
  task automatic txn(input int k, input bit scramble);
    int            g;
    logic [DW-1:0] rv;
    g  = pick();
    rv = '0;
    @(posedge clk);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      chk("mem_read", 64'(mem_read), 64'(!wr_q[g]));
      chk("mem_write", 64'(mem_write), 64'(wr_q[g]));
      chk("mem_address", 64'(mem_address), 64'(ad_q[g]));
      chk("mem_data_in", 64'(mem_data_in), 64'(dt_q[g]));
      chk("ack_busy", 64'(ack), 64'(0));
      exp_busy++;
      if (scramble) begin
        req_address[g*AW +: AW] = AW'($urandom);
        req_data[g*DW +: DW]    = DW'($urandom);
        req_write[g]            = ~wr_q[g];
      end
      mem_ready    = (c == k);
      mem_data_out = DW'($urandom);
      if (c == k && !wr_q[g]) begin
        rv           = mem_rd(ad_q[g]);
        mem_data_out = rv;
      end
    end
    @(negedge clk);
    mem_ready    = 1'($urandom_range(0, 1));
    mem_data_out = DW'($urandom);
    chk("ack", 64'(ack), 64'(1) << g);
    chk("strobes_done", 64'({mem_read, mem_write}), 64'(0));
    if (!wr_q[g]) exp_rdata = rv;
    else mem_m[ad_q[g]] = dt_q[g];
    chk("rdata", 64'(rdata), 64'(exp_rdata));
    exp_last = g;
    exp_gc[g]++;
    pend[g] = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);
    chk("idle_out", 64'({mem_read, mem_write, ack}), 64'(0));
  endtask

  task automatic check_stats();
`ifdef MEMORY_ARBITER_STATS_EN
    for (int i = 0; i < NR; i++)
      chk($sformatf("grant_count%0d", i),
          64'(grant_count[i*STAT_W +: STAT_W]), 64'(exp_gc[i]));
    chk("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
`endif
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    req          = '0;
    req_write    = '0;
    req_address  = '0;
    req_data     = '0;
    mem_ready    = 1'b0;
    mem_data_out = '0;
    exp_last     = NR - 1;
    exp_rdata    = '0;
    exp_busy     = 0;
    for (int i = 0; i < NR; i++) begin
      pend[i]   = 1'b0;
      wr_q[i]   = 1'b0;
      ad_q[i]   = '0;
      dt_q[i]   = '0;
      exp_gc[i] = 0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_strobes", 64'({mem_read, mem_write}), 64'(0));
    chk("rst_addr", 64'(mem_address), 64'(0));
    chk("rst_din", 64'(mem_data_in), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    check_stats();
    rst = 1'b0;

    // Read hit, then write miss, then read-back with inputs scrambled.
    post(0, 1'b0, AW'(1024), DW'(0));
    drive();
    txn(1, 1'b0);
    post(1, 1'b1, AW'('h1234), DW'('hA5));
    drive();
    txn(5, 1'b0);
    post(2, 1'b0, AW'('h1234), DW'('h3C));
    drive();
    txn(2, 1'b1);
    chk("readback", 64'(rdata), 64'('hA5));

    // Two requesters held continuously alternate.
    post(0, 1'b0, AW'(7), DW'(1));
    post(1, 1'b1, AW'(8), DW'(2));
    drive();
    for (int n = 0; n < 4; n++) begin
      txn(4, 1'b1);
      post(exp_last, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           DW'($urandom));
      drive();
    end
    check_stats();
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    drive();
    @(posedge clk);
    @(negedge clk);

    // Reset during the third BUSY cycle.
    post(1, 1'b1, AW'('h55), DW'('h77));
    drive();
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rst_mid_wr", 64'(mem_write), 64'(1));
      mem_ready = 1'b0;
      if (c == 3) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_out", 64'({mem_read, mem_write, ack}), 64'(0));
    chk("rst_mid_rdata", 64'(rdata), 64'(0));
    rst       = 1'b0;
    exp_last  = NR - 1;
    exp_rdata = '0;
    exp_busy  = 0;
    for (int i = 0; i < NR; i++) exp_gc[i] = 0;
    check_stats();
    post(0, 1'b0, AW'('h1234), DW'(0));
    drive();
    txn(1, 1'b0);
    txn(3, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0)
          post(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
               DW'($urandom));
      if (!pend[0] && !pend[1] && !pend[2])
        post(int'($urandom_range(0, NR - 1)), 1'b0,
             AW'($urandom_range(0, 15)), DW'($urandom));
      drive();
      txn(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
    end
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
